// File: rtl/cache_fifo_arb_pkg.sv
// Shared types for the cache request-FIFO write arbiter.
package cache_fifo_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_BURST = 2'd1,
    ARB_FLUSH = 2'd2
  } arb_state_e;

endpackage

// File: rtl/cache_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module cache_rr_pick #(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    idx,
  output logic               any
);

  logic [ID_W-1:0] cand;

  // NOTE: every variable gets a default before the loop so no latch is inferred.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = ID_W'((int'(ptr) + k) % NUM_REQ);
      if (!any && req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
    if (any) grant[idx] = 1'b1;
  end

endmodule

// File: rtl/cache_fifo_wr_arbiter.sv
// Packet-granular round-robin owner of the shared request-FIFO write port; also sequences FIFO flushes.
module cache_fifo_wr_arbiter
  import cache_fifo_arb_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  parameter  int NUM_REQ    = 4,
  parameter  int MAX_BURST  = 4,
  parameter  int FIFO_DEPTH = 16,
  localparam int ID_W       = $clog2(NUM_REQ),
  localparam int ENTRY_W    = DATA_WIDTH + ID_W + 1,
  localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          flush_req,
  output logic                          flush_done,
  output logic                          burst_err,
  output logic                          fifo_write,
  output logic [ENTRY_W-1:0]            fifo_write_data,
  output logic                          fifo_soft_rst,
  input  logic                          fifo_full,
  input  logic [CNT_W-1:0]              fifo_data_num
);

  localparam int              BC_W      = $clog2(MAX_BURST) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(MAX_BURST);
  localparam logic [BC_W-1:0]  LAST_BEAT = BC_W'(MAX_BURST - 1);
  localparam logic [ID_W-1:0]  LAST_ID   = ID_W'(NUM_REQ - 1);

  arb_state_e            state;
  logic [ID_W-1:0]       owner;
  logic [NUM_REQ-1:0]    owner_oh;
  logic [ID_W-1:0]       rr_ptr;
  logic [BC_W-1:0]       beat_cnt;
  logic                  flush_pend;

  logic [NUM_REQ-1:0]    pick_grant;
  logic [ID_W-1:0]       pick_idx;
  logic                  pick_any;
  logic [CNT_W-1:0]      free;
  logic                  can_grant;
  logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];
  logic                  own_valid;
  logic                  own_last;
  logic                  accept;
  logic                  burst_end;

  cache_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) data_arr[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  // A grant needs room for a whole worst-case burst so the owner never stalls on space it was promised.
  assign free      = DEPTH_C - fifo_data_num;
  assign can_grant = pick_any && (free >= THRESH_C);

  assign own_valid = req_valid[owner];
  assign own_last  = req_last[owner];
  assign accept    = (state == ARB_BURST) && own_valid && !fifo_full;
  assign burst_end = accept && (own_last || (beat_cnt == LAST_BEAT));

  assign req_ready       = (state == ARB_BURST && !fifo_full) ? owner_oh : '0;
  assign fifo_write      = accept;
  assign fifo_write_data = {owner, own_last, data_arr[owner]};
  assign fifo_soft_rst   = (state == ARB_FLUSH);
  assign flush_done      = (state == ARB_FLUSH);

  // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ARB_IDLE;
      owner      <= '0;
      owner_oh   <= '0;
      rr_ptr     <= '0;
      beat_cnt   <= '0;
      flush_pend <= 1'b0;
      burst_err  <= 1'b0;
    end else begin
      if (state == ARB_FLUSH)  flush_pend <= 1'b0;
      else if (flush_req)      flush_pend <= 1'b1;

      case (state)
        ARB_IDLE: begin
          if (flush_pend) begin
            state <= ARB_FLUSH;
          end else if (can_grant) begin
            owner    <= pick_idx;
            owner_oh <= pick_grant;
            beat_cnt <= '0;
            state    <= ARB_BURST;
          end
        end
        ARB_BURST: begin
          if (accept) begin
            beat_cnt <= beat_cnt + BC_W'(1);
            if (burst_end) begin
              state  <= ARB_IDLE;
              rr_ptr <= (owner == LAST_ID) ? '0 : owner + ID_W'(1);
              // Cut at MAX_BURST without last: the tail re-arbitrates as a fresh packet.
              if (!own_last) burst_err <= 1'b1;
            end
          end
        end
        ARB_FLUSH: state <= ARB_IDLE;
        default:   state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_fifo_wr_arbiter.sv
// Directed bench for cache_fifo_wr_arbiter: per-cycle model comparison plus hand-computed write/flush timelines.
module tb_cache_fifo_wr_arbiter;

  localparam int DW  = 32;
  localparam int NR  = 4;
  localparam int MB  = 4;
  localparam int FD  = 16;
  localparam int IDW = 2;
  localparam int EW  = DW + IDW + 1;
  localparam int CW  = 5;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NR-1:0]    req_valid;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]    req_last;
  logic [NR-1:0]    req_ready;
  logic             flush_req;
  logic             flush_done;
  logic             burst_err;
  logic             fifo_write;
  logic [EW-1:0]    fifo_write_data;
  logic             fifo_soft_rst;
  logic             fifo_full;
  logic [CW-1:0]    fifo_data_num;

  always #5 clk = ~clk;

  cache_fifo_wr_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .MAX_BURST(MB), .FIFO_DEPTH(FD)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_valid       (req_valid),
    .req_data        (req_data),
    .req_last        (req_last),
    .req_ready       (req_ready),
    .flush_req       (flush_req),
    .flush_done      (flush_done),
    .burst_err       (burst_err),
    .fifo_write      (fifo_write),
    .fifo_write_data (fifo_write_data),
    .fifo_soft_rst   (fifo_soft_rst),
    .fifo_full       (fifo_full),
    .fifo_data_num   (fifo_data_num)
  );

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  typedef struct packed {
    logic ok, busy, flushing, pend, err;
    int   owner, beats, rr;
  } model_t;
  model_t m = '0;

  typedef struct { int cyc; logic [EW-1:0] e; } wr_t;
  wr_t         wr_log[$];
  int          soft_log[$];
  logic [DW:0] src_q [NR][$];
  logic [NR-1:0] hs = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    else n_pass++;
  endtask

  // Model: an owner holds the port for up to MB accepted beats; beats counted from 1.
  function automatic int rr_pick_m(logic [NR-1:0] v, int start);
    int j;
    for (int k = 0; k < NR; k++) begin
      j = (start + k) % NR;
      if (v[j]) return j;
    end
    return 0;
  endfunction

  function automatic model_t model_next(model_t s);
    model_t n;
    n = s;
    if (!rst_n) begin
      n = '0;
      n.ok = 1'b1;
      return n;
    end
    if (s.flushing) begin
      n.flushing = 1'b0;
      n.pend     = 1'b0;
    end else begin
      if (flush_req) n.pend = 1'b1;
      if (s.busy) begin
        if (req_valid[s.owner] && !fifo_full) begin
          n.beats = s.beats + 1;
          if (req_last[s.owner] || n.beats == MB) begin
            n.busy = 1'b0;
            n.rr   = (s.owner + 1) % NR;
            if (!req_last[s.owner]) n.err = 1'b1;
          end
        end
      end else if (s.pend) begin
        n.flushing = 1'b1;
      end else if (req_valid != '0 && (FD - int'(fifo_data_num)) >= MB) begin
        n.busy  = 1'b1;
        n.owner = rr_pick_m(req_valid, s.rr);
        n.beats = 0;
      end
    end
    return n;
  endfunction

  function automatic logic [NR-1:0] exp_ready();
    logic [NR-1:0] one = 1;
    return (m.busy && !fifo_full) ? (one << m.owner) : '0;
  endfunction

  function automatic logic exp_write();
    return m.busy && req_valid[m.owner] && !fifo_full;
  endfunction

  function automatic logic [EW-1:0] exp_wdata();
    return {IDW'(m.owner), req_last[m.owner], req_data[m.owner*DW +: DW]};
  endfunction

  function automatic int cyc_of(int i);
    return (i < wr_log.size()) ? wr_log[i].cyc : -1;
  endfunction

  function automatic int id_of(int i);
    return (i < wr_log.size()) ? int'(wr_log[i].e[EW-1 -: IDW]) : -1;
  endfunction

  function automatic int last_of(int i);
    return (i < wr_log.size()) ? int'(wr_log[i].e[DW]) : -1;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) m <= model_next(m);

  always @(negedge clk) begin
    hs <= req_valid & req_ready;
    if (m.ok) begin
      check("req_ready", 64'(req_ready), 64'(exp_ready()));
      check("fifo_write", 64'(fifo_write), 64'(exp_write()));
      if (exp_write()) check("fifo_write_data", 64'(fifo_write_data), 64'(exp_wdata()));
      check("fifo_soft_rst", 64'(fifo_soft_rst), 64'(m.flushing));
      check("flush_done", 64'(flush_done), 64'(m.flushing));
      check("burst_err", 64'(burst_err), 64'(m.err));
    end
    if (fifo_write === 1'b1) wr_log.push_back('{cyc, fifo_write_data});
    if (fifo_soft_rst === 1'b1) soft_log.push_back(cyc);
  end

  // Requester sources: valid while a queued beat exists, popped after each handshake.
  initial begin
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NR; i++) if (hs[i] === 1'b1) void'(src_q[i].pop_front());
      for (int i = 0; i < NR; i++) begin
        if (src_q[i].size() > 0) begin
          req_valid[i]          = 1'b1;
          req_data[i*DW +: DW]  = src_q[i][0][DW-1:0];
          req_last[i]           = src_q[i][0][DW];
        end else begin
          req_valid[i] = 1'b0;
          req_last[i]  = 1'b0;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_writes(input int n, input int budget);
    int k = 0;
    while (wr_log.size() < n && k < budget) begin
      step();
      k++;
    end
    if (wr_log.size() < n) check("wait_writes timeout", 64'(wr_log.size()), 64'(n));
  endtask

  task automatic push_pkt(input int r, input int beats, input logic [DW-1:0] base);
    for (int b = 0; b < beats; b++) src_q[r].push_back({(b == beats - 1), base + DW'(b)});
  endtask

  initial begin
    int base;
    int c0;
    rst_n         = 1'b0;
    flush_req     = 1'b0;
    fifo_full     = 1'b0;
    fifo_data_num = '0;

    // Reset with every requester valid; requester 0 has two single-beat packets queued.
    push_pkt(0, 1, 32'hA000_0000);
    push_pkt(0, 1, 32'hA000_0004);
    for (int i = 1; i < NR; i++) push_pkt(i, 1, 32'hA000_0000 + DW'(i));
    step();
    #2;
    check("reset req_ready", 64'(req_ready), 64'h0);
    check("reset fifo_write", 64'(fifo_write), 64'h0);
    check("reset burst_err", 64'(burst_err), 64'h0);
    check("reset fifo_soft_rst", 64'(fifo_soft_rst), 64'h0);
    step();
    rst_n = 1'b1;

    // Round robin: ids 0,1,2,3,0 with one idle cycle between writes.
    wait_writes(5, 40);
    check("rr id0", 64'(id_of(0)), 64'd0);
    check("rr id1", 64'(id_of(1)), 64'd1);
    check("rr id2", 64'(id_of(2)), 64'd2);
    check("rr id3", 64'(id_of(3)), 64'd3);
    check("rr id4", 64'(id_of(4)), 64'd0);
    for (int i = 0; i < 4; i++) check("rr gap", 64'(cyc_of(i + 1) - cyc_of(i)), 64'd2);

    // Free-space threshold: 3 free blocks the grant, 4 free allows it next cycle.
    step();
    base = wr_log.size();
    fifo_data_num = CW'(13);
    push_pkt(1, 1, 32'h0000_1111);
    repeat (5) step();
    check("thresh no grant", 64'(wr_log.size()), 64'(base));
    fifo_data_num = CW'(12);
    c0 = cyc;
    wait_writes(base + 1, 10);
    check("thresh write cycle", 64'(cyc_of(base)), 64'(c0 + 1));
    check("thresh id", 64'(id_of(base)), 64'd1);
    fifo_data_num = '0;

    // Overlong packet: cut after beat 4, sole requester regranted for beats 5-6.
    step();
    check("burst_err before", 64'(burst_err), 64'h0);
    base = wr_log.size();
    push_pkt(2, 6, 32'h0000_2000);
    wait_writes(base + 6, 40);
    for (int b = 0; b < 6; b++) begin
      check("long id", 64'(id_of(base + b)), 64'd2);
      check("long last", 64'(last_of(base + b)), 64'(b == 5));
    end
    check("long gap in burst", 64'(cyc_of(base + 1) - cyc_of(base)), 64'd1);
    check("long gap at cut", 64'(cyc_of(base + 4) - cyc_of(base + 3)), 64'd2);
    check("burst_err after", 64'(burst_err), 64'h1);

    // Flush raised on beat 2 of 3: packet completes, one idle cycle, flush, then requester 0.
    repeat (2) step();
    base = wr_log.size();
    push_pkt(3, 3, 32'h0000_3000);
    wait_writes(base + 1, 20);
    flush_req = 1'b1;
    push_pkt(0, 1, 32'h0000_0F0F);
    step();
    flush_req = 1'b0;
    wait_writes(base + 4, 20);
    check("flush count", 64'(soft_log.size()), 64'd1);
    check("flush after packet", 64'(soft_log.size() > 0 ? soft_log[0] : -1), 64'(cyc_of(base + 2) + 2));
    check("grant after flush", 64'(cyc_of(base + 3)), 64'(soft_log.size() > 0 ? soft_log[0] + 2 : -1));
    check("flush pkt id", 64'(id_of(base + 2)), 64'd3);
    check("post flush id", 64'(id_of(base + 3)), 64'd0);

    // Backpressure: full for 3 cycles after beat 1 stalls the burst without consuming beats.
    repeat (2) step();
    base = wr_log.size();
    push_pkt(1, 4, 32'h0000_4000);
    wait_writes(base + 1, 20);
    fifo_full = 1'b1;
    repeat (3) step();
    fifo_full = 1'b0;
    wait_writes(base + 4, 20);
    check("bp stall gap", 64'(cyc_of(base + 1) - cyc_of(base)), 64'd4);
    check("bp gap 2", 64'(cyc_of(base + 2) - cyc_of(base + 1)), 64'd1);
    check("bp gap 3", 64'(cyc_of(base + 3) - cyc_of(base + 2)), 64'd1);
    check("bp last", 64'(last_of(base + 3)), 64'd1);
    check("bp total writes", 64'(wr_log.size()), 64'(base + 4));

    repeat (3) step();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
